dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Shares one synchronous data memory (DM) between N_CORES processor cores for the multi-core build. The DM has 12-bit address, 12-bit data and 1-cycle read latency.
- Each core presents a single-outstanding request/acknowledge port. A 4-state FSM serialises accesses, and a round-robin pointer guarantees fairness.
- Sits between the per-core dm_en/ar_out/bus data paths and the single DM instance.

Parameters:
- N_CORES, 4, number of requesting cores (2..8, need not be a power of two)
- ADDR_W, 12, DM address width
- DATA_W, 12, DM data width
- IDX_W, $clog2(N_CORES), width of the grant index (derived; not overridden)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- arb_en  in  1  high = new grants allowed (tied to start_process)
- req  in  N_CORES  per-core access request, level
- we  in  N_CORES  per-core write select (1 = write, 0 = read)
- addr  in  N_CORES*ADDR_W  flattened per-core address; core i at [i*ADDR_W +: ADDR_W]
- wdata  in  N_CORES*DATA_W  flattened per-core write data
- ack  out  N_CORES  one-hot, 1-cycle completion pulse
- rdata  out  DATA_W  read data, valid in the ack cycle, held until the next read completes
- busy  out  1  high in every non-IDLE state
- grant_idx  out  IDX_W  index of the core being served
- mem_en  out  1  DM access strobe
- mem_we  out  1  DM write enable
- mem_addr  out  ADDR_W  DM address
- mem_wdata  out  DATA_W  DM write data
- mem_rdata  in  DATA_W  DM read data, valid 1 cycle after mem_en

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE, rr_ptr = 0, grant_idx = 0.
  - All outputs = 0: ack, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata.
- All outputs are registered.
- FSM states: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
  - IDLE:
    - If arb_en=1 and any req bit is set, pick winner g = first set req bit searching rr_ptr, rr_ptr+1, ... modulo N_CORES.
    - Latch g into grant_idx and copy addr[g], wdata[g], we[g] into the mem_* registers.
    - Go to ISSUE.
  - ISSUE: mem_en=1 and mem_we=we[g] for exactly 1 cycle; busy=1.
  - WAIT:
    - mem_en=0.
    - For a read, capture mem_rdata into rdata at the end of WAIT.
    - For a write, rdata is unchanged.
  - DONE: ack[g]=1 for exactly 1 cycle; rr_ptr <= (g+1) mod N_CORES; go to IDLE.
- Latency: req sampled at edge t in IDLE -> mem_en high cycle t+1 -> ack high cycle t+3. Throughput: one access per 4 cycles.
- Core contract:
  - addr/wdata/we are held stable from req assertion until ack.
  - On the edge that samples ack, the core drops req or presents a new request. A req still high in IDLE is a new access.
- A req that drops before being granted is ignored; nothing is latched for it.
- arb_en=0: no new grant from IDLE. An access already past IDLE always completes, including its ack.
- Non-power-of-two N_CORES: rr_ptr wraps from N_CORES-1 to 0, never reaching an invalid index.
- Simultaneous requests: exactly one grant per cycle. The others wait, and each is served within N_CORES grants (starvation-free).
- Reset mid-operation: FSM aborts immediately, mem_en drops asynchronously, and no ack is issued for the aborted access.

Optional Feature:
- Macro DM_ARB_COUNT_EN.
- Defined:
  - Adds output grant_cnt (N_CORES*16): per-core saturating 16-bit count of completed accesses, incremented in DONE.
  - Counts stick at 16'hFFFF and reset to 0.
- Undefined: port and counters are absent; all other behaviour is identical.

Decomposition:
- Package dm_arb_pkg holds:
  - State encoding: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DONE=2'd3.
  - Default ADDR_W/DATA_W constants.
  - A clog2 helper function.
- Sub-module rr_pick: combinational round-robin picker with inputs req and rr_ptr, outputs found and idx. Instantiated once.

Test Plan:
- Reset values: hold rst_n=0, then release. Required: all outputs 0 and busy=0; with req=0, mem_en never asserts.
- Single read: core 2 reads addr 12'h05A, DM returns 12'h3C7. Required: mem_en only in cycle t+1 with mem_addr=05A and mem_we=0; ack=4'b0100 at t+3; rdata=3C7.
- Single write: core 1 writes 12'hABC to 12'h010. Required: mem_we=1 with mem_addr=010 and mem_wdata=ABC in the ISSUE cycle; ack=4'b0010; rdata unchanged.
- Fairness: req=4'b1111 held continuously, each core re-requesting after its ack. Required: grant order 0,1,2,3,0,...; with N_CORES=3 the order is 0,1,2,0.
- Gating: arb_en drops during the ISSUE cycle of a grant to core 0. Required: that access still completes with an ack; no further grant occurs until arb_en=1.
- Reset mid-access: pull rst_n low during WAIT. Required: mem_en=0 immediately, no ack, rr_ptr=0 after release. With DM_ARB_COUNT_EN defined, the aborted access is not counted, and 65540 accesses by core 0 leave grant_cnt[0]=16'hFFFF.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the multi-core data-memory arbiter.
// State encoding, default DM geometry and a constant-foldable clog2 helper.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    localparam int DM_ADDR_W = 12;
    localparam int DM_DATA_W = 12;
    localparam int CNT_W     = 16;

    // Usable in parameter defaults; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/dm_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit starting at rr_ptr,
// wrapping modulo N_CORES (N_CORES need not be a power of two).
module rr_pick import dm_arb_pkg::*; #(
    parameter int N_CORES = 4,
    parameter int IDX_W   = clog2(N_CORES)
) (
    input  logic [N_CORES-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    int               w_sum;
    logic [IDX_W-1:0] w_cand;

    // Scan from the farthest offset down so the nearest requester to rr_ptr wins last.
    always_comb begin
        found  = 1'b0;
        idx    = {IDX_W{1'b0}};
        w_sum  = 0;
        w_cand = {IDX_W{1'b0}};
        for (int k = N_CORES - 1; k >= 0; k--) begin
            w_sum  = int'(rr_ptr) + k;
            w_cand = (w_sum >= N_CORES) ? IDX_W'(w_sum - N_CORES) : IDX_W'(w_sum);
            found  = found | req[w_cand];
            idx    = req[w_cand] ? w_cand : idx;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-latency data memory between N_CORES cores.
// Optional per-core saturating access counters under `DM_ARB_COUNT_EN.
module dm_arbiter import dm_arb_pkg::*; #(
    parameter  int N_CORES = 4,
    parameter  int ADDR_W  = DM_ADDR_W,
    parameter  int DATA_W  = DM_DATA_W,
    localparam int IDX_W   = clog2(N_CORES)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       arb_en,
    input  logic [N_CORES-1:0]         req,
    input  logic [N_CORES-1:0]         we,
    input  logic [N_CORES*ADDR_W-1:0]  addr,
    input  logic [N_CORES*DATA_W-1:0]  wdata,
    output logic [N_CORES-1:0]         ack,
    output logic [DATA_W-1:0]          rdata,
    output logic                       busy,
    output logic [IDX_W-1:0]           grant_idx,
    output logic                       mem_en,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata
`ifdef DM_ARB_COUNT_EN
    ,
    output logic [N_CORES*CNT_W-1:0]   grant_cnt
`endif
);

    arb_state_e         r_state;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_grant_idx;
    logic               r_is_write;
    logic [N_CORES-1:0] r_ack;
    logic [DATA_W-1:0]  r_rdata;
    logic               r_busy;
    logic               r_mem_en;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;

    logic               w_found;
    logic [IDX_W-1:0]   w_pick_idx;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;
    logic               w_sel_we;
    logic [IDX_W-1:0]   w_next_ptr;
    logic [N_CORES-1:0] w_onehot;

    rr_pick #(
        .N_CORES (N_CORES),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (r_rr_ptr),
        .found  (w_found),
        .idx    (w_pick_idx)
    );

    // Mux the winning core's request fields and derive the post-service pointer.
    always_comb begin
        w_sel_addr  = addr[int'(w_pick_idx)*ADDR_W +: ADDR_W];
        w_sel_wdata = wdata[int'(w_pick_idx)*DATA_W +: DATA_W];
        w_sel_we    = we[w_pick_idx];
        w_next_ptr  = (r_grant_idx == IDX_W'(N_CORES - 1)) ? {IDX_W{1'b0}}
                                                            : r_grant_idx + {{(IDX_W-1){1'b0}}, 1'b1};
        w_onehot    = {{(N_CORES-1){1'b0}}, 1'b1} << r_grant_idx;
    end

    // Access sequencer: IDLE grants, ISSUE strobes the DM, WAIT captures read data, DONE acks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rr_ptr    <= {IDX_W{1'b0}};
            r_grant_idx <= {IDX_W{1'b0}};
            r_is_write  <= 1'b0;
            r_ack       <= {N_CORES{1'b0}};
            r_rdata     <= {DATA_W{1'b0}};
            r_busy      <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {ADDR_W{1'b0}};
            r_mem_wdata <= {DATA_W{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if (arb_en && w_found) begin
                        r_state     <= ISSUE;
                        r_grant_idx <= w_pick_idx;
                        r_is_write  <= w_sel_we;
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_wdata;
                        r_mem_we    <= w_sel_we;
                        r_mem_en    <= 1'b1;
                        r_busy      <= 1'b1;
                    end else begin
                        r_state     <= IDLE;
                    end
                end
                ISSUE: begin
                    r_state  <= WAIT;
                    r_mem_en <= 1'b0;
                    r_mem_we <= 1'b0;
                end
                WAIT: begin
                    r_state <= DONE;
                    r_ack   <= w_onehot;
                    // The DM returns read data one cycle after the strobe, i.e. during WAIT.
                    if (!r_is_write) begin
                        r_rdata <= mem_rdata;
                    end else begin
                        r_rdata <= r_rdata;
                    end
                end
                DONE: begin
                    r_state  <= IDLE;
                    r_ack    <= {N_CORES{1'b0}};
                    r_busy   <= 1'b0;
                    r_rr_ptr <= w_next_ptr;
                end
                default: begin
                    r_state  <= IDLE;
                    r_ack    <= {N_CORES{1'b0}};
                    r_busy   <= 1'b0;
                    r_mem_en <= 1'b0;
                    r_mem_we <= 1'b0;
                end
            endcase
        end
    end

    assign ack       = r_ack;
    assign rdata     = r_rdata;
    assign busy      = r_busy;
    assign grant_idx = r_grant_idx;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

`ifdef DM_ARB_COUNT_EN
    logic [CNT_W-1:0] r_cnt [N_CORES];

    // Per-core completed-access counters; an access aborted by reset never reaches DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CORES; i++) begin
                r_cnt[i] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < N_CORES; i++) begin
                if ((r_state == DONE) && (r_grant_idx == IDX_W'(i)) && (r_cnt[i] != {CNT_W{1'b1}})) begin
                    r_cnt[i] <= r_cnt[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    r_cnt[i] <= r_cnt[i];
                end
            end
        end
    end

    for (genvar gi = 0; gi < N_CORES; gi++) begin : g_cnt_out
        assign grant_cnt[gi*CNT_W +: CNT_W] = r_cnt[gi];
    end
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Randomized self-checking bench for dm_arbiter against a transaction-level model
// that predicts grant timing, winner order, DM traffic and read data.
module tb_dm_arbiter;

    localparam int N  = 4;
    localparam int AW = 12;
    localparam int DW = 12;
    localparam int IW = 2;

    logic            clk    = 1'b0;
    logic            rst_n  = 1'b0;
    logic            arb_en = 1'b1;
    logic [N-1:0]    req    = '0;
    logic [N-1:0]    we     = '0;
    logic [N*AW-1:0] addr   = '0;
    logic [N*DW-1:0] wdata  = '0;

    logic [N-1:0]    ack;
    logic [DW-1:0]   rdata;
    logic            busy;
    logic [IW-1:0]   grant_idx;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;
`ifdef DM_ARB_COUNT_EN
    logic [N*16-1:0] grant_cnt;
`endif

    dm_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arb_en    (arb_en),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .ack       (ack),
        .rdata     (rdata),
        .busy      (busy),
        .grant_idx (grant_idx),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef DM_ARB_COUNT_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] init_f(input int a);
        return 12'((a * 29 + 341) & 32'hFFF);
    endfunction

    // Behavioural DM: 1-cycle read latency, plus a preload path for directed tests.
    logic          pl_en   = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;
    logic [DW-1:0] dm [4096];
    bit            dm_valid [4096];

    always @(posedge clk) begin
        if (pl_en) begin
            dm[pl_addr]       <= pl_data;
            dm_valid[pl_addr] <= 1'b1;
        end else if (mem_en && mem_we) begin
            dm[mem_addr]       <= mem_wdata;
            dm_valid[mem_addr] <= 1'b1;
        end
        if (mem_en && !mem_we) mem_rdata <= dm_valid[mem_addr] ? dm[mem_addr] : init_f(int'(mem_addr));
    end

    // Reference model state
    logic [DW-1:0] ref_mem [4096];
    int            cyc = 0;
    int            gcyc, free_at, rr, g;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata, exp_rdata, rd_val;
    int            gcnt [N];
    bit            pend [N];
    int            oq[$];
    int            ackq[$];
    int            n_vec = 0;
    int            n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        gcyc = -100; free_at = 0; rr = 0; exp_rdata = '0; exp_we = 1'b0;
        for (int i = 0; i < N; i++) gcnt[i] = 0;
    endtask

    // One clock: model decides the grant from the sampled inputs, then outputs are checked.
    task automatic step();
        @(posedge clk);
        cyc++;
        if (rst_n && arb_en && cyc >= free_at && req != '0) begin
            g         = pick(req, rr);
            gcyc      = cyc;
            free_at   = cyc + 4;
            rr        = (g + 1) % N;
            exp_we    = we[g];
            exp_addr  = addr[g*AW +: AW];
            exp_wdata = wdata[g*DW +: DW];
            if (exp_we) ref_mem[exp_addr] = exp_wdata;
            else        rd_val = ref_mem[exp_addr];
        end
        #1;
        if (mem_en) oq.push_back(int'(grant_idx));
        if (ack != '0) ackq.push_back(int'(ack));
        if (cyc == gcyc + 2) begin
            if (!exp_we) exp_rdata = rd_val;
            gcnt[g]++;
        end
        chk("mem_en", mem_en, cyc == gcyc);
        chk("mem_we", mem_we, (cyc == gcyc) && exp_we);
        chk("busy", busy, (cyc >= gcyc) && (cyc <= gcyc + 2));
        chk("ack", ack, (cyc == gcyc + 2) ? (32'd1 << g) : 32'd0);
        chk("rdata", rdata, exp_rdata);
        if (cyc == gcyc) begin
            chk("mem_addr", mem_addr, exp_addr);
            chk("mem_wdata", mem_wdata, exp_wdata);
        end
        if ((cyc >= gcyc) && (cyc <= gcyc + 2)) chk("grant_idx", grant_idx, g);
    endtask

    task automatic apply_reset(input int n);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_mem_en", mem_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ack", ack, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_grant_idx", grant_idx, 0);
        chk("rst_mem_bus", {mem_we, mem_addr, mem_wdata}, 0);
        repeat (n) step();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run(input int n, input bit rereq);
        for (int k = 0; k < n; k++) begin
            step();
            @(negedge clk);
            if (cyc == gcyc + 2 && !rereq) req[g] = 1'b0;
        end
    endtask

    task automatic new_req(input int i);
        pend[i]             = 1'b1;
        req[i]              = 1'b1;
        we[i]               = 1'($urandom_range(1, 0));
        addr[i*AW +: AW]    = AW'($urandom_range(63, 0));
        wdata[i*DW +: DW]   = DW'($urandom);
    endtask

    task automatic drive_random();
        for (int i = 0; i < N; i++) begin
            bit acked, inflight;
            acked    = (cyc == gcyc + 2) && (g == i);
            inflight = (cyc >= gcyc) && (cyc <= gcyc + 2) && (g == i);
            if (acked) begin
                pend[i] = 1'b0; req[i] = 1'b0;
                if ($urandom_range(1, 0) == 1) new_req(i);
            end else if (!pend[i]) begin
                if ($urandom_range(3, 0) == 0) new_req(i);
            end else if (!inflight && $urandom_range(15, 0) == 0) begin
                pend[i] = 1'b0; req[i] = 1'b0;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_f(i);
        model_reset();
        apply_reset(3);

        // Preload DM[05A] = 3C7
        pl_en = 1'b1; pl_addr = 12'h05A; pl_data = 12'h3C7; ref_mem[12'h05A] = 12'h3C7;
        run(1, 1'b0);
        pl_en = 1'b0;

        // Single read by core 2
        oq.delete(); ackq.delete();
        req = 4'b0100; we = 4'b0000; addr[2*AW +: AW] = 12'h05A;
        run(6, 1'b0);
        chk("rd_ack_count", ackq.size(), 1);
        if (ackq.size() > 0) chk("rd_ack_vec", ackq[0], 4'b0100);
        if (oq.size() > 0) chk("rd_grant", oq[0], 2);
        chk("rd_data", rdata, 12'h3C7);

        // Single write by core 1, then read it back through core 3
        oq.delete(); ackq.delete();
        req = 4'b0010; we = 4'b0010; addr[1*AW +: AW] = 12'h010; wdata[1*DW +: DW] = 12'hABC;
        run(6, 1'b0);
        chk("wr_ack_count", ackq.size(), 1);
        if (ackq.size() > 0) chk("wr_ack_vec", ackq[0], 4'b0010);
        chk("wr_rdata_held", rdata, 12'h3C7);
        req = 4'b1000; we = 4'b0000; addr[3*AW +: AW] = 12'h010;
        run(6, 1'b0);
        chk("wr_readback", rdata, 12'hABC);

        // Fairness with all cores requesting continuously
        apply_reset(2);
        oq.delete(); ackq.delete();
        req = 4'b1111; we = 4'b0000;
        run(20, 1'b1);
        chk("fair_grants", oq.size(), 5);
        for (int k = 0; k < 5 && k < oq.size(); k++) chk("fair_order", oq[k], k % N);

        // arb_en drops during ISSUE of a grant to core 0
        apply_reset(2);
        oq.delete(); ackq.delete();
        req = 4'b0001;
        step();
        @(negedge clk);
        arb_en = 1'b0; req = 4'b1111;
        run(10, 1'b1);
        chk("gate_grants", oq.size(), 1);
        chk("gate_acks", ackq.size(), 1);
        if (ackq.size() > 0) chk("gate_ack_vec", ackq[0], 4'b0001);
        chk("gate_idle", busy, 0);
        arb_en = 1'b1;
        run(2, 1'b1);
        chk("gate_resume", oq.size(), 2);
        if (oq.size() > 1) chk("gate_next", oq[1], 1);

        // Reset during WAIT: no ack, pointer back to 0
        apply_reset(2);
        oq.delete(); ackq.delete();
        req = 4'b1000;
        step(); step();
        #2;
        apply_reset(2);
        chk("abort_no_ack", ackq.size(), 0);
        oq.delete();
        req = 4'b1111;
        run(2, 1'b1);
        if (oq.size() > 0) chk("abort_rr_ptr", oq[0], 0);
        chk("abort_regrant", oq.size(), 1);

        // Reset during ISSUE: mem_en must drop immediately (checked inside apply_reset)
        apply_reset(2);
        req = 4'b0100;
        step();
        #2;
        apply_reset(2);

        // Randomized traffic
        apply_reset(2);
        req = '0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            step();
            @(negedge clk);
            drive_random();
            arb_en = ($urandom_range(7, 0) != 0);
        end

`ifdef DM_ARB_COUNT_EN
        for (int i = 0; i < N; i++) chk("grant_cnt", grant_cnt[i*16 +: 16], (gcnt[i] > 65535) ? 65535 : gcnt[i]);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
